// File: rtl/spec_accumulator_if.sv
// Stream bundle for spec_accumulator: power-spectrum input, run control and the
// accumulated-spectrum readout with its status flags.
interface spec_accumulator_if #(
  parameter int BINS  = 512,
  parameter int IN_W  = 50,
  parameter int ACC_W = 64,
  parameter int CNT_W = 16
);
  localparam int IDX_W = $clog2(BINS);

  logic             start;
  logic [CNT_W-1:0] acc_num;
  logic [IN_W-1:0]  Power_Spec;
  logic             data_valid;
  logic             dv_FFT;

  logic [ACC_W-1:0] acc_data;
  logic [IDX_W-1:0] acc_index;
  logic             acc_valid;
  logic             acc_last;
  logic             acc_done;
  logic             busy;
  logic             sat;
  logic             frame_err;
  logic             overrun;

  modport master (
    output start, acc_num, Power_Spec, data_valid, dv_FFT,
    input  acc_data, acc_index, acc_valid, acc_last, acc_done,
           busy, sat, frame_err, overrun
  );

  modport slave (
    input  start, acc_num, Power_Spec, data_valid, dv_FFT,
    output acc_data, acc_index, acc_valid, acc_last, acc_done,
           busy, sat, frame_err, overrun
  );
endinterface

// File: rtl/spec_accumulator.sv
// Sums N consecutive power-spectrum frames into a BINS-deep RAM with a
// read-modify-write pipeline, then streams the summed spectrum out bin by bin.
module spec_accumulator #(
  parameter int BINS  = 512,
  parameter int IN_W  = 50,
  parameter int ACC_W = 64,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  spec_accumulator_if.slave bus
);
  localparam int IDX_W = $clog2(BINS);
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(BINS - 1);

  typedef enum logic [1:0] {IDLE, ARM, ACCUM, DUMP} state_t;
  state_t state, state_next;

  logic [ACC_W-1:0] mem [BINS];
  logic [ACC_W-1:0] ram_q;
  logic             rd_en;
  logic [IDX_W-1:0] rd_addr;

  logic [CNT_W-1:0] n_latched;
  logic [CNT_W-1:0] frame_cnt;
  logic [IDX_W-1:0] bin_cnt;
  logic [IDX_W-1:0] dump_cnt;
  logic             dump_rd_done;
  logic             dv_d;

  logic             wr_pending;
  logic [IDX_W-1:0] wr_addr;
  logic [IN_W-1:0]  ps_d;
  logic             first_frame_d;
  logic             fwd;
  logic [ACC_W-1:0] fwd_data;

  logic             s1_valid;
  logic [IDX_W-1:0] s1_index;
  logic             s1_last;

  logic [ACC_W-1:0] acc_data;
  logic [IDX_W-1:0] acc_index;
  logic             acc_valid, acc_last, acc_done;
  logic             sat, frame_err, overrun;

  logic             beat, short_frame, dump_rd, sat_hit;
  logic [ACC_W-1:0] old_val, sum;
  logic [ACC_W:0]   wide;

  assign beat        = (state == ACCUM) && bus.data_valid && (frame_cnt != n_latched);
  assign short_frame = (state == ACCUM) && dv_d && !bus.dv_FFT && (bin_cnt != '0);
  assign dump_rd     = (state == DUMP) && !dump_rd_done;

  // A one-beat short frame can make the next read hit the bin still being
  // written, so that case takes the in-flight sum instead of the RAM data.
  always_comb begin
    old_val = fwd ? fwd_data : ram_q;
    wide    = {1'b0, old_val} + (ACC_W + 1)'(ps_d);
    sat_hit = 1'b0;
    if (first_frame_d) begin
      sum = ACC_W'(ps_d);
    end else if (wide[ACC_W]) begin
      sum     = '1;
      sat_hit = wr_pending;
    end else begin
      sum = wide[ACC_W-1:0];
    end
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    rd_addr    = bin_cnt;
    case (state)
      IDLE:  if (bus.start) state_next = ARM;
      ARM:   if (!bus.data_valid) state_next = ACCUM;
      ACCUM: begin
        rd_en = beat;
        if (frame_cnt == n_latched) state_next = DUMP;
      end
      DUMP: begin
        rd_en   = dump_rd;
        rd_addr = dump_cnt;
        if (acc_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_pending) mem[wr_addr] <= sum;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      n_latched     <= '0;
      frame_cnt     <= '0;
      bin_cnt       <= '0;
      dump_cnt      <= '0;
      dump_rd_done  <= 1'b0;
      dv_d          <= 1'b0;
      wr_pending    <= 1'b0;
      wr_addr       <= '0;
      ps_d          <= '0;
      first_frame_d <= 1'b0;
      fwd           <= 1'b0;
      fwd_data      <= '0;
      s1_valid      <= 1'b0;
      s1_index      <= '0;
      s1_last       <= 1'b0;
      acc_data      <= '0;
      acc_index     <= '0;
      acc_valid     <= 1'b0;
      acc_last      <= 1'b0;
      acc_done      <= 1'b0;
      sat           <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state      <= state_next;
      dv_d       <= bus.dv_FFT;
      wr_pending <= beat;
      if (beat) begin
        wr_addr       <= bin_cnt;
        ps_d          <= bus.Power_Spec;
        first_frame_d <= (frame_cnt == '0);
        fwd           <= wr_pending && (wr_addr == bin_cnt);
        fwd_data      <= sum;
      end
      if (sat_hit) sat <= 1'b1;

      if (state == IDLE && bus.start) begin
        n_latched    <= (bus.acc_num == '0) ? CNT_W'(1) : bus.acc_num;
        frame_cnt    <= '0;
        bin_cnt      <= '0;
        dump_cnt     <= '0;
        dump_rd_done <= 1'b0;
        sat          <= 1'b0;
        frame_err    <= 1'b0;
        overrun      <= 1'b0;
      end

      if (short_frame) begin
        frame_err <= 1'b1;
        bin_cnt   <= '0;
      end else if (beat) begin
        bin_cnt <= bin_cnt + 1'b1;
        if (bin_cnt == LAST_BIN) frame_cnt <= frame_cnt + 1'b1;
      end

      if (dump_rd) begin
        dump_cnt <= dump_cnt + 1'b1;
        if (dump_cnt == LAST_BIN) dump_rd_done <= 1'b1;
      end
      if (state == DUMP && bus.data_valid) overrun <= 1'b1;

      s1_valid  <= dump_rd;
      s1_index  <= dump_cnt;
      s1_last   <= dump_rd && (dump_cnt == LAST_BIN);
      acc_valid <= s1_valid;
      acc_index <= s1_index;
      acc_last  <= s1_last;
      acc_data  <= s1_valid ? ram_q : '0;
      acc_done  <= acc_last;
    end
  end

  assign bus.acc_data  = acc_data;
  assign bus.acc_index = acc_index;
  assign bus.acc_valid = acc_valid;
  assign bus.acc_last  = acc_last;
  assign bus.acc_done  = acc_done;
  assign bus.busy      = (state != IDLE);
  assign bus.sat       = sat;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;
endmodule

// File: tb/tb_spec_accumulator.sv
// Directed bench for spec_accumulator: a 64-bit instance for the main scenarios
// and a 51-bit instance so saturation is reachable within three frames.
module tb_spec_accumulator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start, sel, dv, dvf;
  logic [15:0] acc_num;
  logic [49:0] ps;

  spec_accumulator_if #(.ACC_W(64)) ia ();
  spec_accumulator_if #(.ACC_W(51)) ib ();

  spec_accumulator #(.ACC_W(64)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  spec_accumulator #(.ACC_W(51)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  assign ia.start      = start & ~sel;
  assign ib.start      = start & sel;
  assign ia.acc_num    = acc_num;
  assign ib.acc_num    = acc_num;
  assign ia.Power_Spec = ps;
  assign ib.Power_Spec = ps;
  assign ia.data_valid = dv;
  assign ib.data_valid = dv;
  assign ia.dv_FFT     = dvf;
  assign ib.dv_FFT     = dvf;

  wire [63:0] m_data  = sel ? 64'(ib.acc_data) : ia.acc_data;
  wire [8:0]  m_index = sel ? ib.acc_index : ia.acc_index;
  wire        m_valid = sel ? ib.acc_valid : ia.acc_valid;
  wire        m_last  = sel ? ib.acc_last  : ia.acc_last;
  wire        m_done  = sel ? ib.acc_done  : ia.acc_done;
  wire        m_busy  = sel ? ib.busy      : ia.busy;
  wire        m_sat   = sel ? ib.sat       : ia.sat;
  wire        m_ferr  = sel ? ib.frame_err : ia.frame_err;
  wire        m_ovr   = sel ? ib.overrun   : ia.overrun;

  int checks = 0;
  int errors = 0;

  int          last_beat_cyc, cap_first_cyc;
  bit          cap_timeout;
  logic        cap_done_end, cap_busy_end, cap_done_next;
  logic        got_valid [512];
  logic [63:0] got_data  [512];
  logic [8:0]  got_idx   [512];
  logic        got_last  [512];

  task automatic do_start(input logic s, input logic [15:0] n);
    @(negedge clk);
    sel = s; start = 1'b1; acc_num = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_frame(input int n, input bit ramp, input logic [49:0] val, input int gap);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      dv = 1'b1; dvf = 1'b1;
      ps = ramp ? 50'(k) : val;
      last_beat_cyc = cyc;
    end
    @(negedge clk);
    dv = 1'b0; dvf = 1'b0; ps = '0;
    repeat (gap) @(negedge clk);
  endtask

  // Records one full dump; with inject set, data_valid pulses twice mid-dump.
  task automatic capture_dump(input bit inject);
    int budget = 0;
    cap_timeout = 1'b0;
    for (int i = 0; i < 512; i++) got_valid[i] = 1'b0;
    while (m_valid !== 1'b1 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (m_valid !== 1'b1) begin
      cap_timeout = 1'b1;
      return;
    end
    cap_first_cyc = cyc;
    for (int i = 0; i < 512; i++) begin
      got_valid[i] = m_valid;
      got_data[i]  = m_data;
      got_idx[i]   = m_index;
      got_last[i]  = m_last;
      dv = inject && (i == 10 || i == 200);
      @(negedge clk);
    end
    dv = 1'b0;
    cap_done_end = m_done;
    cap_busy_end = m_busy;
    @(negedge clk);
    cap_done_next = m_done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 1'b0; dv = 1'b0; dvf = 1'b0; ps = '0; acc_num = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ia.acc_valid !== 1'b0 || ib.acc_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b/%b expected 0/0", ia.acc_valid, ib.acc_valid);
    end
    checks++;
    if (ia.acc_data !== 64'd0 || ia.acc_index !== 9'd0) begin
      errors++; $display("[TB] FAIL reset_data: got %0h idx %0d expected 0 idx 0", ia.acc_data, ia.acc_index);
    end
    checks++;
    if ({ia.busy, ia.acc_last, ia.acc_done} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 000", {ia.busy, ia.acc_last, ia.acc_done});
    end
    checks++;
    if ({ia.sat, ia.frame_err, ia.overrun, ib.sat, ib.frame_err, ib.overrun} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 000000",
                         {ia.sat, ia.frame_err, ia.overrun, ib.sat, ib.frame_err, ib.overrun});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ia.busy !== 1'b0 || ib.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_after_reset: busy got %b/%b expected 0/0", ia.busy, ib.busy);
    end
  endtask

  task automatic test_ramp_single();
    int bad = 0, first_bad = 0;
    do_start(1'b0, 16'd1);
    checks++;
    if (m_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_after_start: got %b expected 1", m_busy);
    end
    drive_frame(512, 1'b1, '0, 0);
    capture_dump(1'b0);
    checks++;
    if (cap_timeout !== 1'b0) begin
      errors++; $display("[TB] FAIL ramp_timeout: got timeout=%b expected 0", cap_timeout);
    end
    checks++;
    if (cap_first_cyc - last_beat_cyc !== 4) begin
      errors++; $display("[TB] FAIL ramp_latency: got %0d cycles expected 4", cap_first_cyc - last_beat_cyc);
    end
    for (int i = 0; i < 512; i++)
      if (got_valid[i] !== 1'b1 || got_data[i] !== 64'(i)) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL ramp_data: %0d bad bins, bin %0d got %0h expected %0h",
                         bad, first_bad, got_data[first_bad], 64'(first_bad));
    end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (got_idx[i] !== 9'(i)) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL ramp_index: %0d bad, slot %0d got %0d expected %0d",
                         bad, first_bad, got_idx[first_bad], first_bad);
    end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (got_last[i] !== (i == 511)) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL ramp_last: %0d bad, slot %0d got %b expected %b",
                         bad, first_bad, got_last[first_bad], first_bad == 511);
    end
    checks++;
    if (cap_done_end !== 1'b1 || cap_busy_end !== 1'b0) begin
      errors++; $display("[TB] FAIL ramp_done: done/busy got %b/%b expected 1/0", cap_done_end, cap_busy_end);
    end
    checks++;
    if (cap_done_next !== 1'b0) begin
      errors++; $display("[TB] FAIL ramp_done_pulse: got %b expected 0", cap_done_next);
    end
    checks++;
    if ({m_sat, m_ferr, m_ovr} !== 3'b000) begin
      errors++; $display("[TB] FAIL ramp_flags: got %b expected 000", {m_sat, m_ferr, m_ovr});
    end
  endtask

  task automatic test_multi_frame();
    int bad = 0, first_bad = 0;
    do_start(1'b0, 16'd3);
    drive_frame(512, 1'b0, 50'd100, 3);
    drive_frame(512, 1'b0, 50'd100, 3);
    drive_frame(512, 1'b0, 50'd100, 0);
    capture_dump(1'b0);
    for (int i = 0; i < 512; i++)
      if (got_valid[i] !== 1'b1 || got_data[i] !== 64'd300) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL sum3_data: %0d bad bins, bin %0d got %0d expected 300",
                         bad, first_bad, got_data[first_bad]);
    end
    bad = 0;
    do_start(1'b0, 16'd1);
    drive_frame(512, 1'b0, 50'd7, 0);
    capture_dump(1'b0);
    for (int i = 0; i < 512; i++)
      if (got_valid[i] !== 1'b1 || got_data[i] !== 64'd7) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL overwrite_data: %0d bad bins, bin %0d got %0d expected 7",
                         bad, first_bad, got_data[first_bad]);
    end
  endtask

  task automatic test_start_mid_frame();
    int bad = 0, first_bad = 0;
    sel = 1'b0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      dv = 1'b1; dvf = 1'b1; ps = 50'd77;
      start = (k == 312); acc_num = 16'd1;
    end
    @(negedge clk);
    dv = 1'b0; dvf = 1'b0; start = 1'b0; ps = '0;
    drive_frame(512, 1'b0, 50'd5, 0);
    capture_dump(1'b0);
    for (int i = 0; i < 512; i++)
      if (got_valid[i] !== 1'b1 || got_data[i] !== 64'd5) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL partial_skip_data: %0d bad bins, bin %0d got %0d expected 5",
                         bad, first_bad, got_data[first_bad]);
    end
    checks++;
    if (m_ferr !== 1'b0) begin
      errors++; $display("[TB] FAIL partial_skip_ferr: got %b expected 0", m_ferr);
    end
  endtask

  task automatic test_saturation();
    int bad = 0, first_bad = 0;
    logic [63:0] exp_sat = 64'h0007_FFFF_FFFF_FFFF;
    do_start(1'b1, 16'd3);
    drive_frame(512, 1'b0, 50'h3_FFFF_FFFF_FFFF, 3);
    drive_frame(512, 1'b0, 50'h3_FFFF_FFFF_FFFF, 3);
    drive_frame(512, 1'b0, 50'h3_FFFF_FFFF_FFFF, 0);
    capture_dump(1'b0);
    for (int i = 0; i < 512; i++)
      if (got_valid[i] !== 1'b1 || got_data[i] !== exp_sat) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL sat_data: %0d bad bins, bin %0d got %0h expected %0h",
                         bad, first_bad, got_data[first_bad], exp_sat);
    end
    checks++;
    if (m_sat !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_flag: got %b expected 1", m_sat);
    end
    sel = 1'b0;
  endtask

  task automatic test_short_frame();
    int bad = 0, first_bad = 0;
    do_start(1'b0, 16'd2);
    drive_frame(300, 1'b0, 50'd1, 3);
    drive_frame(512, 1'b0, 50'd1, 3);
    drive_frame(512, 1'b0, 50'd1, 0);
    capture_dump(1'b0);
    for (int i = 0; i < 512; i++)
      if (got_valid[i] !== 1'b1 || got_data[i] !== 64'd2) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL short_frame_data: %0d bad bins, bin %0d got %0d expected 2",
                         bad, first_bad, got_data[first_bad]);
    end
    checks++;
    if (m_ferr !== 1'b1) begin
      errors++; $display("[TB] FAIL short_frame_flag: got %b expected 1", m_ferr);
    end
  endtask

  task automatic test_overrun_and_reset();
    int bad = 0, first_bad = 0, budget = 0, stray = 0;
    do_start(1'b0, 16'd0);
    drive_frame(512, 1'b0, 50'd9, 0);
    ps = 50'h12345;
    capture_dump(1'b1);
    ps = '0;
    for (int i = 0; i < 512; i++)
      if (got_valid[i] !== 1'b1 || got_data[i] !== 64'd9) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL overrun_data: %0d bad bins, bin %0d got %0d expected 9",
                         bad, first_bad, got_data[first_bad]);
    end
    checks++;
    if (m_ovr !== 1'b1) begin
      errors++; $display("[TB] FAIL overrun_flag: got %b expected 1", m_ovr);
    end
    do_start(1'b0, 16'd1);
    checks++;
    if (m_ovr !== 1'b0) begin
      errors++; $display("[TB] FAIL overrun_clear: got %b expected 0", m_ovr);
    end
    drive_frame(512, 1'b0, 50'd3, 0);
    while (!(m_valid === 1'b1 && m_index === 9'd100) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (m_index !== 9'd100 || m_data !== 64'd3) begin
      errors++; $display("[TB] FAIL dump_idx100: got idx %0d data %0d expected idx 100 data 3", m_index, m_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_valid, m_last, m_done, m_busy} !== 4'b0000) begin
      errors++; $display("[TB] FAIL rst_mid_dump_ctrl: got %b expected 0000", {m_valid, m_last, m_done, m_busy});
    end
    checks++;
    if (m_data !== 64'd0 || m_index !== 9'd0) begin
      errors++; $display("[TB] FAIL rst_mid_dump_data: got %0h idx %0d expected 0 idx 0", m_data, m_index);
    end
    rst = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || m_busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("[TB] FAIL rst_no_resume: got %0d active cycles expected 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_single();
    test_multi_frame();
    test_start_mid_frame();
    test_saturation();
    test_short_frame();
    test_overrun_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
